mod_addsub_ctrl: RTL and testbench
==================================

Name: mod_addsub_ctrl

Overview:
Sequencer that turns the shared 1027-bit multiprecision adder (mpadder: start/subtract/in_a/in_b in, 1028-bit result/done out) into a modular adder/subtractor. It computes (a+b) mod m or (a−b) mod m in two adder passes: a raw add/sub, then a conditional correction by m. It sits between the Montgomery/exponentiation control and the single mpadder instance, and owns that adder's control inputs while active.

Parameters:
N, 1027, operand/modulus width; adder result width is N+1.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
op_sub  in  1  0: (a+b) mod m, 1: (a−b) mod m; latched with start
in_a  in  N  operand a, a < m
in_b  in  N  operand b, b < m
in_m  in  N  modulus m, 0 < m < 2^(N−1)
result  out  N  modular result, held until next accepted start
done  out  1  one-cycle pulse when result is valid
busy  out  1  high from accepted start until the done cycle inclusive
add_start  out  1  one-cycle start pulse to mpadder
add_subtract  out  1  mpadder subtract select
add_a  out  N  mpadder in_a
add_b  out  N  mpadder in_b
add_result  in  N+1  mpadder result; bit N is carry (add) / borrow-sign (sub)
add_done  in  1  mpadder completion

Behaviour:
- Reset values: result=0, done=0, busy=0, add_start=0, add_subtract=0, add_a=0, add_b=0; state=IDLE.
- States: IDLE, P1_GO, P1_WAIT, P2_GO, P2_WAIT, FIN.
- IDLE: on start=1 latch in_a, in_b, in_m, op_sub; busy=1; → P1_GO.
- P1_GO (1 cycle): add_a=a, add_b=b, add_subtract=op_sub, add_start=1; → P1_WAIT.
- P1_WAIT: add_start=0; add_a/add_b/add_subtract held stable. On add_done=1 latch r1=add_result; → P2_GO.
- P2_GO (1 cycle): add_a=r1[N−1:0], add_b=m, add_start=1; add_subtract = ~op_sub (add pass subtracts m, sub pass adds m); → P2_WAIT.
- P2_WAIT: hold inputs; on add_done=1 latch r2=add_result; → FIN.
- Selection in FIN: add: result = r2[N]==0 ? r2[N−1:0] : r1[N−1:0]. sub: result = r1[N]==1 ? r2[N−1:0] : r1[N−1:0]. done=1 for exactly this cycle, busy=1; → IDLE (busy=0 next cycle).
- Second pass always executes (constant-time; no data-dependent skip).
- Width rule: m < 2^(N−1) guarantees a+b < 2^N, so r1[N] = 0 for add and r1[N−1:0] is exact; sub correction result is truncated to N bits (wrap intended).
- Latency: start-to-done = 4 + L1 + L2 cycles, where Lk = cycles from add_start to add_done for pass k.
- start while busy (any non-IDLE state, including FIN) is ignored, no queuing.
- add_done outside P1_WAIT/P2_WAIT is ignored; add_done in the same cycle as add_start (GO states) is ignored.
- reset mid-operation: immediate return to IDLE, all outputs to reset values, latched operands discarded; mpadder shares the same reset.
- Operand range violations (a≥m, b≥m, m≥2^(N−1)) give undefined result but FSM still completes and pulses done.

Decomposition:
- Shared package: N, state encoding constants (IDLE..FIN), opcode constants OP_ADD=0/OP_SUB=1.
- No sub-module inside; mpadder is instantiated beside this block by the parent. Bench uses a behavioural mpadder model with programmable latency plus the real mpadder.

Test Plan:
- m=13, add 7+9 → result=3, done pulse once, busy low the cycle after; add 2+3 → 5 (correction rejected, r2 negative).
- m=13, sub 3−9 → 7 (borrow, +m applied); sub 9−3 → 6; sub 5−5 → 0.
- Large: m=2^1025+0x1F, a=b=m−1, add → m−2; sub a=0,b=m−1 → 1; cross-check against real mpadder.
- Adder model latency 1 and 37: start-to-done equals 4+L1+L2 exactly; add_a/add_b/add_subtract constant throughout each WAIT.
- start pulsed in P1_WAIT and in FIN with different operands → ignored; first result unchanged, no extra done.
- reset asserted in P2_WAIT → next cycle all outputs 0, state IDLE; fresh start 7+9 mod 13 → 3.

Source files
------------

// File: rtl/mod_addsub_ctrl_pkg.sv
// Shared constants for the modular add/sub sequencer.
// Operand width, FSM encoding and opcode values.
package mod_addsub_ctrl_pkg;

    localparam int N = 1027;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P1_GO   = 3'd1,
        P1_WAIT = 3'd2,
        P2_GO   = 3'd3,
        P2_WAIT = 3'd4,
        FIN     = 3'd5
    } state_t;

endpackage

// File: rtl/mod_addsub_ctrl.sv
// Two-pass modular add/sub sequencer driving a shared mpadder.
// Pass 1 computes a+/-b, pass 2 applies the -/+m correction.
module mod_addsub_ctrl
    import mod_addsub_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op_sub,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic [N-1:0] result,
    output logic         done,
    output logic         busy,
    output logic         add_start,
    output logic         add_subtract,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    input  logic [N:0]   add_result,
    input  logic         add_done
);

    state_t state;
    state_t state_nxt;

    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [N-1:0] m_q;
    logic         op_q;
    logic [N:0]   r1_q;
    logic [N-1:0] sel_res;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // add_result in P2_WAIT is r2; the selection is folded into its capture
    always_comb begin
        sel_res = r1_q[N-1:0];
        if (op_q == OP_ADD) begin
            if (!add_result[N]) begin
                sel_res = add_result[N-1:0];
            end
        end else begin
            if (r1_q[N]) begin
                sel_res = add_result[N-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            op_q   <= OP_ADD;
            r1_q   <= '0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q  <= in_a;
                        b_q  <= in_b;
                        m_q  <= in_m;
                        op_q <= op_sub;
                    end
                end
                P1_WAIT: begin
                    if (add_done) begin
                        r1_q <= add_result;
                    end
                end
                P2_WAIT: begin
                    if (add_done) begin
                        result <= sel_res;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt    = state;
        done         = 1'b0;
        busy         = 1'b1;
        add_start    = 1'b0;
        add_subtract = 1'b0;
        add_a        = '0;
        add_b        = '0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = P1_GO;
                end
            end
            P1_GO: begin
                add_start    = 1'b1;
                add_subtract = op_q;
                add_a        = a_q;
                add_b        = b_q;
                state_nxt    = P1_WAIT;
            end
            P1_WAIT: begin
                add_subtract = op_q;
                add_a        = a_q;
                add_b        = b_q;
                if (add_done) begin
                    state_nxt = P2_GO;
                end
            end
            P2_GO: begin
                add_start    = 1'b1;
                add_subtract = ~op_q;
                add_a        = r1_q[N-1:0];
                add_b        = m_q;
                state_nxt    = P2_WAIT;
            end
            P2_WAIT: begin
                add_subtract = ~op_q;
                add_a        = r1_q[N-1:0];
                add_b        = m_q;
                if (add_done) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Directed bench for mod_addsub_ctrl with a behavioural
// mpadder of programmable per-pass latency.
module tb_mod_addsub_ctrl;
    import mod_addsub_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op_sub;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [N-1:0] in_m;
    logic [N-1:0] result;
    logic         done;
    logic         busy;
    logic         add_start;
    logic         add_subtract;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic [N:0]   add_result;
    logic         add_done;

    int nvec = 0;
    int nerr = 0;
    int lat1 = 1;
    int lat2 = 1;

    always #5 clk = ~clk;

    mod_addsub_ctrl dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op_sub(op_sub),
        .in_a(in_a),
        .in_b(in_b),
        .in_m(in_m),
        .result(result),
        .done(done),
        .busy(busy),
        .add_start(add_start),
        .add_subtract(add_subtract),
        .add_a(add_a),
        .add_b(add_b),
        .add_result(add_result),
        .add_done(add_done)
    );

    // Behavioural mpadder: add_done goes high Lk cycles after add_start
    int  cnt;
    bit  pend;
    bit  pass2;
    always @(posedge clk) begin
        add_done <= 1'b0;
        if (reset) begin
            pend       <= 1'b0;
            pass2      <= 1'b0;
            cnt        <= 0;
            add_result <= '0;
        end else if (add_start) begin
            if (add_subtract)
                add_result <= {1'b0, add_a} - {1'b0, add_b};
            else
                add_result <= {1'b0, add_a} + {1'b0, add_b};
            pass2 <= ~pass2;
            if ((pass2 ? lat2 : lat1) == 1) begin
                add_done <= 1'b1;
            end else begin
                cnt  <= (pass2 ? lat2 : lat1) - 1;
                pend <= 1'b1;
            end
        end else if (pend) begin
            if (cnt == 1) begin
                add_done <= 1'b1;
                pend     <= 1'b0;
            end
            cnt <= cnt - 1;
        end
    end

    // Drives one operation; reports result, inclusive start-to-done
    // cycle count, done pulses seen, and input stability in WAIT.
    task automatic run_op(
        input  logic         op,
        input  logic [N-1:0] a,
        input  logic [N-1:0] b,
        input  logic [N-1:0] m,
        output logic [N-1:0] res,
        output int           cyc,
        output int           ndone,
        output bit           stable,
        output bit           busy_after
    );
        logic [N-1:0] ca;
        logic [N-1:0] cb;
        logic         cs;
        bit           fin;
        ca = '0; cb = '0; cs = 1'b0;
        stable = 1'b1;
        fin = 1'b0;
        ndone = 0;
        res = '0;
        @(negedge clk);
        start = 1'b1; op_sub = op;
        in_a = a; in_b = b; in_m = m;
        cyc = 1;
        @(negedge clk);
        start = 1'b0;
        in_a = '0; in_b = '0; in_m = '0;
        while (!fin && cyc < 400) begin
            cyc++;
            if (add_start) begin
                ca = add_a; cb = add_b; cs = add_subtract;
            end else if (busy && !done) begin
                if (add_a !== ca || add_b !== cb ||
                    add_subtract !== cs)
                    stable = 1'b0;
            end
            if (done) begin
                fin = 1'b1;
                ndone++;
                res = result;
            end else begin
                @(negedge clk);
            end
        end
        if (!fin) cyc = -1;
        @(negedge clk);
        busy_after = busy;
        for (int i = 0; i < 4; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op_sub = 1'b0;
        in_a = '0; in_b = '0; in_m = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        nvec++;
        if ({done, busy, add_start, add_subtract} !== 4'b0 ||
            result !== '0 || add_a !== '0 || add_b !== '0) begin
            nerr++;
            $display("FAIL reset: done=%b busy=%b st=%b sub=%b res0=%b a0=%b b0=%b",
                     done, busy, add_start, add_subtract,
                     result == '0, add_a == '0, add_b == '0);
        end
    endtask

    task automatic test_small();
        logic [N-1:0] vm, va, vb, exp, res;
        logic         op;
        int           cyc, nd;
        bit           st, ba;
        logic [N*3:0] vec [5];
        logic [N-1:0] exps [5];
        vec[0] = {OP_ADD, N'(13), N'(7), N'(9)}; exps[0] = N'(3);
        vec[1] = {OP_ADD, N'(13), N'(2), N'(3)}; exps[1] = N'(5);
        vec[2] = {OP_SUB, N'(13), N'(3), N'(9)}; exps[2] = N'(7);
        vec[3] = {OP_SUB, N'(13), N'(9), N'(3)}; exps[3] = N'(6);
        vec[4] = {OP_SUB, N'(13), N'(5), N'(5)}; exps[4] = N'(0);
        lat1 = 2; lat2 = 3;
        for (int i = 0; i < 5; i++) begin
            {op, vm, va, vb} = vec[i];
            exp = exps[i];
            run_op(op, va, vb, vm, res, cyc, nd, st, ba);
            nvec++;
            if (res !== exp || nd != 1 || ba !== 1'b0) begin
                nerr++;
                $display("FAIL small[%0d]: res=%0d exp=%0d dones=%0d (exp 1) busy_after=%b (exp 0)",
                         i, res[15:0], exp[15:0], nd, ba);
            end
        end
    endtask

    task automatic test_large();
        logic [N-1:0] m, res, exp;
        int           cyc, nd;
        bit           st, ba;
        lat1 = 4; lat2 = 2;
        m = (N'(1) << 1025) + N'(31);
        exp = m - N'(2);
        run_op(OP_ADD, m - N'(1), m - N'(1), m, res, cyc, nd, st, ba);
        nvec++;
        if (res !== exp || nd != 1) begin
            nerr++;
            $display("FAIL large_add: res_lo=%h exp_lo=%h hi_ok=%b dones=%0d",
                     res[63:0], exp[63:0], res[N-1:64] == exp[N-1:64], nd);
        end
        exp = N'(1);
        run_op(OP_SUB, N'(0), m - N'(1), m, res, cyc, nd, st, ba);
        nvec++;
        if (res !== exp || nd != 1) begin
            nerr++;
            $display("FAIL large_sub: res_lo=%h exp_lo=%h hi_ok=%b dones=%0d",
                     res[63:0], exp[63:0], res[N-1:64] == exp[N-1:64], nd);
        end
    endtask

    task automatic test_latency();
        logic [N-1:0] res;
        int           cyc, nd;
        bit           st, ba;
        int           l1s [3] = '{1, 37, 5};
        int           l2s [3] = '{1, 37, 19};
        for (int i = 0; i < 3; i++) begin
            lat1 = l1s[i]; lat2 = l2s[i];
            run_op(OP_ADD, N'(7), N'(9), N'(13), res, cyc, nd, st, ba);
            nvec++;
            if (cyc != 4 + lat1 + lat2 || res !== N'(3)) begin
                nerr++;
                $display("FAIL latency L1=%0d L2=%0d: cycles=%0d exp=%0d res=%0d exp 3",
                         lat1, lat2, cyc, 4 + lat1 + lat2, res[15:0]);
            end
            nvec++;
            if (st !== 1'b1) begin
                nerr++;
                $display("FAIL hold L1=%0d L2=%0d: adder inputs changed in WAIT (stable=%b exp 1)",
                         lat1, lat2, st);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nd;
        int cyc;
        lat1 = 5; lat2 = 5;
        nd = 0;
        @(negedge clk);
        start = 1'b1; op_sub = OP_SUB;
        in_a = N'(9); in_b = N'(3); in_m = N'(13);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op_sub = OP_ADD;
        in_a = N'(2); in_b = N'(3); in_m = N'(13);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (done) nd++;
        start = 1'b1; op_sub = OP_ADD;
        in_a = N'(7); in_b = N'(9); in_m = N'(13);
        @(negedge clk);
        start = 1'b0;
        nvec++;
        if (busy !== 1'b0 || result !== N'(6)) begin
            nerr++;
            $display("FAIL ignore_start: busy=%b (exp 0) res=%0d (exp 6)",
                     busy, result[15:0]);
        end
        for (int i = 0; i < 20; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        nvec++;
        if (nd != 1 || result !== N'(6)) begin
            nerr++;
            $display("FAIL no_extra_done: dones=%0d exp 1 res=%0d exp 6",
                     nd, result[15:0]);
        end
    endtask

    task automatic test_mid_reset();
        logic [N-1:0] res;
        int           cyc, nd, starts;
        bit           st, ba;
        lat1 = 3; lat2 = 10;
        starts = 0;
        @(negedge clk);
        start = 1'b1; op_sub = OP_ADD;
        in_a = N'(2); in_b = N'(3); in_m = N'(13);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 30 && starts < 2; i++) begin
            if (add_start) starts++;
            @(negedge clk);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        nvec++;
        if ({done, busy, add_start, add_subtract} !== 4'b0 ||
            result !== '0 || add_a !== '0 || add_b !== '0 ||
            starts != 2) begin
            nerr++;
            $display("FAIL mid_reset: done=%b busy=%b st=%b sub=%b res=%0d a=%0d b=%0d passes=%0d",
                     done, busy, add_start, add_subtract,
                     result[15:0], add_a[15:0], add_b[15:0], starts);
        end
        run_op(OP_ADD, N'(7), N'(9), N'(13), res, cyc, nd, st, ba);
        nvec++;
        if (res !== N'(3) || nd != 1) begin
            nerr++;
            $display("FAIL after_reset: res=%0d exp 3 dones=%0d",
                     res[15:0], nd);
        end
    endtask

    initial begin
        test_reset();
        test_small();
        test_large();
        test_latency();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
